// File: rtl/gpmc_regmem_pkg.sv
// Shared types and constants for the GPMC banked register/memory target.
package gpmc_regmem_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT_IDLE} state_t;

   // Source of the registered read data seen on data_out
   typedef enum logic [1:0] {OUT_REG, OUT_BANK, OUT_ZERO} out_sel_t;

   localparam logic [2:0] REG_ID           = 3'd0;
   localparam logic [2:0] REG_BANK_SEL     = 3'd1;
   localparam logic [2:0] REG_WR_COUNT     = 3'd2;
   localparam logic [2:0] REG_RD_COUNT     = 3'd3;
   localparam logic [2:0] REG_SCRATCH      = 3'd4;
   localparam logic [2:0] REG_LAST_WR_ADDR = 3'd5;
   localparam logic [2:0] REG_ERR          = 3'd6;
   localparam logic [2:0] REG_RSVD         = 3'd7;

   localparam logic [15:0] DEFAULT_ID_VALUE = 16'hBE01;

   function automatic int bank_sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gpmc_regmem_bank.sv
// One RAM bank of the memory window: synchronous write port plus a
// synchronous read port whose output holds while re is low.
module gpmc_regmem_bank #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

   // A read colliding with a write to the same word returns the old contents
   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      if (re)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/gpmc_banked_regmem.sv
// GPMC target: register page in the lower half, banked RAM window in the upper half.
// Define GPMC_BANKED_REGMEM_ERRCNT_EN to build the ERR_COUNT error counter.
module gpmc_banked_regmem
   import gpmc_regmem_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter int          DATA_WIDTH = 16,
   parameter int          NUM_BANKS  = 4,
   parameter logic [15:0] ID_VALUE   = DEFAULT_ID_VALUE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs_n,
   input  logic                  we_n,
   input  logic                  oe_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int BSW        = bank_sel_width(NUM_BANKS);
   localparam int OFS_W      = ADDR_WIDTH - 1;
   localparam int BANK_SLOTS = 1 << BSW;

   logic                  wr_act, rd_act;
   state_t                state, next_state;
   logic                  commit, commit_ok, start_wr, start_rd, cap_en, rd_sample;
   logic [ADDR_WIDTH-1:0] cap_addr, last_wr_addr;
   logic [DATA_WIDTH-1:0] cap_data, scratch, wr_count, rd_count, reg_rdata, reg_q;
   logic [BSW-1:0]        bank_sel, rd_bank_q;
   logic                  bank_valid, rd_is_win, cap_is_win, wr_clr, rd_clr;
   logic [2:0]            rd_idx, cap_idx;
   out_sel_t              out_sel;
   logic [DATA_WIDTH-1:0] bank_rdata [BANK_SLOTS];

   assign wr_act     = !cs_n && !we_n && oe_n;
   assign rd_act     = !cs_n && we_n && !oe_n;
   assign rd_is_win  = address[ADDR_WIDTH-1];
   assign rd_idx     = address[2:0];
   assign cap_is_win = cap_addr[ADDR_WIDTH-1];
   assign cap_idx    = cap_addr[2:0];
   assign bank_valid = 32'(bank_sel) < NUM_BANKS;
   assign commit_ok  = commit && !rst;
   assign wr_clr     = commit_ok && !cap_is_win && (cap_idx == REG_WR_COUNT);
   assign rd_clr     = commit_ok && !cap_is_win && (cap_idx == REG_RD_COUNT);

   always_ff @(posedge clk) begin
      if (rst)
         state <= WAIT_IDLE;
      else
         state <= next_state;
   end

   // A write commits on the first cycle its strobe is gone, possibly while a read starts
   always_comb begin
      next_state = state;
      commit     = 1'b0;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      case (state)
         IDLE: begin
            if (wr_act) begin
               next_state = WRITE;
               start_wr   = 1'b1;
            end else if (rd_act) begin
               next_state = READ;
               start_rd   = 1'b1;
            end
         end
         WRITE: begin
            if (!wr_act) begin
               commit = 1'b1;
               if (rd_act) begin
                  next_state = READ;
                  start_rd   = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         READ: begin
            if (!rd_act)
               next_state = IDLE;
         end
         WAIT_IDLE: begin
            if (!wr_act && !rd_act)
               next_state = IDLE;
         end
         default: next_state = WAIT_IDLE;
      endcase
      cap_en    = (next_state == WRITE);
      rd_sample = (next_state == READ);
   end

   always_ff @(posedge clk) begin
      if (cap_en) begin
         cap_addr <= address;
         cap_data <= data_in;
      end
   end

   // Counters clear on a committed write to themselves; a read starting in the same cycle still counts
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_sel     <= '0;
         wr_count     <= '0;
         rd_count     <= '0;
         scratch      <= '0;
         last_wr_addr <= '0;
      end else begin
         if (commit_ok) begin
            last_wr_addr <= cap_addr;
            if (!cap_is_win) begin
               case (cap_idx)
                  REG_BANK_SEL: bank_sel <= cap_data[BSW-1:0];
                  REG_SCRATCH:  scratch  <= cap_data;
                  default: ;
               endcase
            end
         end
         if (wr_clr)
            wr_count <= '0;
         else if (start_wr)
            wr_count <= wr_count + 1'b1;
         rd_count <= (rd_clr ? '0 : rd_count) + DATA_WIDTH'(start_rd);
      end
   end

`ifdef GPMC_BANKED_REGMEM_ERRCNT_EN
   logic [DATA_WIDTH-1:0] err_count;
   logic                  wr_err, rd_err;

   // Each transaction adds at most one error; a write commit and a read start may coincide
   always_comb begin
      wr_err = commit_ok && (cap_is_win ? !bank_valid :
               (cap_idx == REG_ID || cap_idx == REG_LAST_WR_ADDR ||
                cap_idx == REG_ERR || cap_idx == REG_RSVD));
      rd_err = start_rd && (rd_is_win ? !bank_valid : (rd_idx == REG_RSVD));
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else
         err_count <= err_count + DATA_WIDTH'(wr_err) + DATA_WIDTH'(rd_err);
   end
`endif

   always_comb begin
      reg_rdata = '0;
      case (rd_idx)
         REG_ID:           reg_rdata = DATA_WIDTH'(ID_VALUE);
         REG_BANK_SEL:     reg_rdata = DATA_WIDTH'(bank_sel);
         REG_WR_COUNT:     reg_rdata = wr_count;
         REG_RD_COUNT:     reg_rdata = rd_count;
         REG_SCRATCH:      reg_rdata = scratch;
         REG_LAST_WR_ADDR: reg_rdata = DATA_WIDTH'(last_wr_addr);
`ifdef GPMC_BANKED_REGMEM_ERRCNT_EN
         REG_ERR:          reg_rdata = err_count;
         REG_RSVD:         reg_rdata = '0;
`else
         REG_ERR, REG_RSVD: reg_rdata = '0;
`endif
         default:          reg_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_q     <= '0;
         rd_bank_q <= '0;
         out_sel   <= OUT_REG;
      end else if (rd_sample) begin
         reg_q     <= reg_rdata;
         rd_bank_q <= bank_sel;
         out_sel   <= !rd_is_win ? OUT_REG : (bank_valid ? OUT_BANK : OUT_ZERO);
      end
   end

   always_comb begin
      case (out_sel)
         OUT_BANK: data_out = bank_rdata[rd_bank_q];
         OUT_ZERO: data_out = '0;
         default:  data_out = reg_q;
      endcase
   end

   // Unused select codes (BANK_SEL >= NUM_BANKS) get a constant-zero slot
   for (genvar i = 0; i < BANK_SLOTS; i++) begin : g_bank
      if (i < NUM_BANKS) begin : g_ram
         gpmc_regmem_bank #(
            .ADDR_WIDTH (OFS_W),
            .DATA_WIDTH (DATA_WIDTH)
         ) u_bank (
            .clk     (clk),
            .we      (commit_ok && cap_is_win && (bank_sel == BSW'(i))),
            .wr_addr (cap_addr[OFS_W-1:0]),
            .wr_data (cap_data),
            .re      (rd_sample && rd_is_win && (bank_sel == BSW'(i))),
            .rd_addr (address[OFS_W-1:0]),
            .rd_data (bank_rdata[i])
         );
      end else begin : g_none
         assign bank_rdata[i] = '0;
      end
   end

endmodule

// File: tb/tb_gpmc_banked_regmem.sv
// Self-checking bench for gpmc_banked_regmem (three banks, so BANK_SEL=3 is out of range).
module tb_gpmc_banked_regmem;
   import gpmc_regmem_pkg::*;

`ifdef GPMC_BANKED_REGMEM_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cs_n = 1'b1, we_n = 1'b1, oe_n = 1'b1;
   logic [9:0]  address = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;

   int total = 0;
   int bad   = 0;

   // Transaction-level reference state
   logic [15:0] mem_m [4][8];
   logic [1:0]  bank_sel_m;
   logic [15:0] wr_m, rd_m, scratch_m, err_m, last_exp;
   logic [9:0]  last_wr_m;
   bit          pend_valid;
   logic [9:0]  pend_addr;
   logic [15:0] pend_data;

   typedef struct {
      bit          is_wr;
      logic [9:0]  addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [20];

   gpmc_banked_regmem #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (16),
      .NUM_BANKS  (3),
      .ID_VALUE   (16'hBE01)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cs_n     (cs_n),
      .we_n     (we_n),
      .oe_n     (oe_n),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      bank_sel_m = '0; wr_m = '0; rd_m = '0; scratch_m = '0;
      err_m = '0; last_wr_m = '0; last_exp = '0; pend_valid = 1'b0;
   endfunction

   function automatic logic [15:0] modelReadVal(input logic [9:0] a);
      if (a[9])
         return (int'(bank_sel_m) < 3) ? mem_m[bank_sel_m][a[2:0]] : 16'h0;
      case (a[2:0])
         3'd0: return 16'hBE01;
         3'd1: return {14'd0, bank_sel_m};
         3'd2: return wr_m;
         3'd3: return rd_m;
         3'd4: return scratch_m;
         3'd5: return {6'd0, last_wr_m};
         3'd6: return ERR_EN ? err_m : 16'h0;
         default: return 16'h0;
      endcase
   endfunction

   function automatic void modelCommit(input logic [9:0] a, input logic [15:0] d);
      last_wr_m = a;
      if (a[9]) begin
         if (int'(bank_sel_m) < 3) mem_m[bank_sel_m][a[2:0]] = d;
         else if (ERR_EN) err_m++;
      end else begin
         case (a[2:0])
            3'd1: bank_sel_m = d[1:0];
            3'd2: wr_m = '0;
            3'd3: rd_m = '0;
            3'd4: scratch_m = d;
            default: if (ERR_EN) err_m++;
         endcase
      end
   endfunction

   function automatic void modelStartRead(input logic [9:0] a);
      rd_m++;
      if (ERR_EN && (a[9] ? int'(bank_sel_m) >= 3 : a[2:0] == 3'd7)) err_m++;
   endfunction

   function automatic logic [9:0] randAddr();
      if ($urandom_range(0, 1) == 1) return {1'b1, 6'd0, 3'($urandom)};
      return {1'b0, 6'($urandom), 3'($urandom)};
   endfunction

   task automatic applyStimulus(input bit wr, input bit rd, input logic [9:0] a, input logic [15:0] d);
      cs_n = !(wr || rd);
      we_n = !wr;
      oe_n = !rd;
      address = a;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic idleCycle();
      if (pend_valid) begin
         modelCommit(pend_addr, pend_data);
         pend_valid = 1'b0;
      end
      applyStimulus(1'b0, 1'b0, randAddr(), 16'($urandom));
      checkOutput("hold", data_out, last_exp);
   endtask

   task automatic writeCycles(input int n, input logic [9:0] a, input logic [15:0] d);
      wr_m++;
      for (int k = 0; k < n - 1; k++) begin
         applyStimulus(1'b1, 1'b0, randAddr(), 16'($urandom));
         checkOutput("wr_hold", data_out, last_exp);
      end
      applyStimulus(1'b1, 1'b0, a, d);
      pend_valid = 1'b1;
      pend_addr = a;
      pend_data = d;
   endtask

   task automatic readCycle(input logic [9:0] a, input bit first, input string name, output logic [15:0] got);
      logic [15:0] exp;
      exp = modelReadVal(a);
      if (pend_valid) begin
         modelCommit(pend_addr, pend_data);
         pend_valid = 1'b0;
      end
      if (first) modelStartRead(a);
      applyStimulus(1'b0, 1'b1, a, 16'($urandom));
      got = data_out;
      last_exp = exp;
      checkOutput(name, got, exp);
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0);
      rst = 1'b0;
      modelReset();
      checkOutput("reset_dout", data_out, 16'h0);
      idleCycle();
   endtask

   task automatic writeTxn(input logic [9:0] a, input logic [15:0] d);
      writeCycles(1, a, d);
      idleCycle();
   endtask

   task automatic readTxn(input logic [9:0] a, input string name, output logic [15:0] got);
      readCycle(a, 1'b1, name, got);
      idleCycle();
   endtask

   initial begin
      logic [15:0] got, old_val, w0;
      int n;

      vecs[0]  = '{1'b0, 10'h000, 16'h0000, 16'hBE01};
      vecs[1]  = '{1'b0, 10'h003, 16'h0000, 16'h0001};
      vecs[2]  = '{1'b1, 10'h004, 16'h0055, 16'h0000};
      vecs[3]  = '{1'b0, 10'h004, 16'h0000, 16'h0055};
      vecs[4]  = '{1'b0, 10'h002, 16'h0000, 16'h0001};
      vecs[5]  = '{1'b0, 10'h005, 16'h0000, 16'h0004};
      vecs[6]  = '{1'b1, 10'h001, 16'h0002, 16'h0000};
      vecs[7]  = '{1'b1, 10'h200, 16'h1234, 16'h0000};
      vecs[8]  = '{1'b0, 10'h200, 16'h0000, 16'h1234};
      vecs[9]  = '{1'b0, 10'h001, 16'h0000, 16'h0002};
      vecs[10] = '{1'b1, 10'h002, 16'hFFFF, 16'h0000};
      vecs[11] = '{1'b0, 10'h002, 16'h0000, 16'h0000};
      vecs[12] = '{1'b0, 10'h007, 16'h0000, 16'h0000};
      vecs[13] = '{1'b1, 10'h007, 16'hAAAA, 16'h0000};
      vecs[14] = '{1'b0, 10'h007, 16'h0000, 16'h0000};
      vecs[15] = '{1'b0, 10'h003, 16'h0000, 16'h000A};
      vecs[16] = '{1'b1, 10'h003, 16'h1111, 16'h0000};
      vecs[17] = '{1'b0, 10'h003, 16'h0000, 16'h0000};
      vecs[18] = '{1'b0, 10'h006, 16'h0000, ERR_EN ? 16'h0003 : 16'h0000};
      vecs[19] = '{1'b0, 10'h005, 16'h0000, 16'h0003};

      doReset();
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].is_wr) begin
            writeTxn(vecs[i].addr, vecs[i].data);
         end else begin
            readTxn(vecs[i].addr, "vec_model", got);
            checkOutput($sformatf("vec%0d", i), got, vecs[i].exp);
         end
      end

      // Known contents in offsets 0..7 of every bank
      for (int b = 0; b < 3; b++) begin
         writeTxn(10'h001, 16'(b));
         for (int o = 0; o < 8; o++)
            writeTxn({1'b1, 6'd0, 3'(o)}, 16'($urandom));
      end

      // First read after reset sees counters before its own increment
      doReset(); readTxn(10'h001, "rst_bank_sel", got); checkOutput("rst_bank_sel_c", got, 16'h0);
      doReset(); readTxn(10'h002, "rst_wr_cnt", got);   checkOutput("rst_wr_cnt_c", got, 16'h0);
      doReset(); readTxn(10'h003, "rst_rd_cnt", got);   checkOutput("rst_rd_cnt_c", got, 16'h0);
      readTxn(10'h003, "rd_cnt_one", got);              checkOutput("rd_cnt_one_c", got, 16'h1);

      // Bank switching around the same window word
      old_val = mem_m[0][0];
      writeTxn(10'h001, 16'h0002);
      writeTxn(10'h200, 16'h1234);
      writeTxn(10'h001, 16'h0000);
      readTxn(10'h200, "bank0_old", got);  checkOutput("bank0_old_c", got, old_val);
      writeTxn(10'h001, 16'h0002);
      readTxn(10'h200, "bank2_new", got);  checkOutput("bank2_new_c", got, 16'h1234);

      // Long write burst commits only the last word, counted once
      readTxn(10'h002, "burst_w0", w0);
      wr_m++;
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 1'b0, 10'h004, 16'h00A0 + 16'(k));
      pend_valid = 1'b1; pend_addr = 10'h004; pend_data = 16'h00A4;
      idleCycle();
      readTxn(10'h004, "burst_scratch", got); checkOutput("burst_scratch_c", got, 16'h00A4);
      readTxn(10'h002, "burst_wr_cnt", got);  checkOutput("burst_wr_cnt_c", got, w0 + 16'h1);

      // Reset in the middle of a write, strobe still low afterwards
      writeTxn(10'h004, 16'h0055);
      readTxn(10'h004, "pre_rst_scratch", got); checkOutput("pre_rst_scratch_c", got, 16'h0055);
      applyStimulus(1'b1, 1'b0, 10'h004, 16'h0077);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 10'h004, 16'h0088);
      rst = 1'b0;
      modelReset();
      checkOutput("midrst_dout", data_out, 16'h0);
      repeat (3) applyStimulus(1'b1, 1'b0, 10'h004, 16'h0099);
      idleCycle();
      readTxn(10'h004, "midrst_scratch", got); checkOutput("midrst_scratch_c", got, 16'h0);
      readTxn(10'h002, "midrst_wr_cnt", got);  checkOutput("midrst_wr_cnt_c", got, 16'h0);
      writeTxn(10'h004, 16'h0066);
      readTxn(10'h002, "post_rst_wr_cnt", got); checkOutput("post_rst_wr_cnt_c", got, 16'h1);

      // Out-of-range bank: write dropped, read returns zero
      doReset();
      writeTxn(10'h001, 16'h0003);
      writeTxn(10'h200, 16'hBEEF);
      readTxn(10'h200, "badbank_rd", got); checkOutput("badbank_rd_c", got, 16'h0);
      readTxn(10'h006, "badbank_err", got); checkOutput("badbank_err_c", got, ERR_EN ? 16'h2 : 16'h0);
      writeTxn(10'h001, 16'h0002);

      // Software clear of WR_COUNT
      doReset();
      for (int k = 0; k < 4; k++) writeTxn(10'h004, 16'(k));
      readTxn(10'h002, "wr_cnt_four", got); checkOutput("wr_cnt_four_c", got, 16'h4);
      writeTxn(10'h002, 16'h5A5A);
      readTxn(10'h002, "wr_cnt_clr", got);  checkOutput("wr_cnt_clr_c", got, 16'h0);

      // Random transactions against the reference model
      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(0, 2))
            0: begin
               writeCycles($urandom_range(1, 4), randAddr(), 16'($urandom));
               idleCycle();
            end
            1: begin
               n = $urandom_range(1, 4);
               for (int k = 0; k < n; k++) readCycle(randAddr(), k == 0, "rnd_read", got);
               idleCycle();
            end
            default: begin
               writeCycles($urandom_range(1, 3), randAddr(), 16'($urandom));
               n = $urandom_range(1, 3);
               for (int k = 0; k < n; k++) readCycle(randAddr(), k == 0, "rnd_wr_rd", got);
               idleCycle();
            end
         endcase
         if ($urandom_range(0, 3) == 0) idleCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
